// File: rtl/complex_exec_pipe.sv
// complex_exec_pipe: pipelined unsigned multiplier plus an iterative restoring divider
// sharing one registered writeback port. Optional feature macro: COMPLEX_DIV_EARLY_OUT_EN.
module complex_exec_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 7,
  parameter int MUL_LAT    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [1:0]            in_op,
  input  logic [DATA_WIDTH-1:0] in_src1,
  input  logic [DATA_WIDTH-1:0] in_src2,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  div_busy,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [TAG_WIDTH-1:0]  out_tag
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_e;

  logic                 accept, acc_mul, acc_div;
  logic [2*W-1:0]       prod;
  logic [W-1:0]         mul_res;
  logic                 mul_done;
  logic [W-1:0]         mul_data;
  logic [TAG_WIDTH-1:0] mul_tag;

  assign accept  = in_valid & ~flush & (~in_op[1] | ~div_busy);
  assign acc_mul = accept & ~in_op[1];
  assign acc_div = accept &  in_op[1];
  assign prod    = {{W{1'b0}}, in_src1} * {{W{1'b0}}, in_src2};
  assign mul_res = in_op[0] ? prod[2*W-1:W] : prod[W-1:0];

  // The shared out register is the last multiply stage, so MUL_LAT-1 stages live here.
  generate
    if (MUL_LAT == 1) begin : g_mul_comb
      assign mul_done = acc_mul;
      assign mul_data = mul_res;
      assign mul_tag  = in_tag;
    end else begin : g_mul_pipe
      localparam int STAGES = MUL_LAT - 1;
      logic [STAGES:1]                vld_pipe;
      logic [STAGES:1][W-1:0]         res_pipe;
      logic [STAGES:1][TAG_WIDTH-1:0] tag_pipe;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          vld_pipe <= '0;
          res_pipe <= '0;
          tag_pipe <= '0;
        end else begin
          vld_pipe[1] <= acc_mul;
          res_pipe[1] <= mul_res;
          tag_pipe[1] <= in_tag;
          for (int i = 2; i <= STAGES; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            res_pipe[i] <= res_pipe[i-1];
            tag_pipe[i] <= tag_pipe[i-1];
          end
          if (flush) vld_pipe <= '0;
        end
      end

      assign mul_done = vld_pipe[STAGES];
      assign mul_data = res_pipe[STAGES];
      assign mul_tag  = tag_pipe[STAGES];
    end
  endgenerate

  div_state_e           div_st, div_nxt;
  logic [W-1:0]         d_rem, d_quo, d_dvs, diff;
  logic [CW-1:0]        d_cnt;
  logic                 d_rem_op;
  logic [TAG_WIDTH-1:0] d_tag;
  logic [W:0]           trial;
  logic                 fits, early, div_done;

  // Restoring step: shift next dividend bit into the partial remainder, subtract if it fits.
  assign trial    = {d_rem, d_quo[W-1]};
  assign fits     = trial >= {1'b0, d_dvs};
  assign diff     = trial[W-1:0] - d_dvs;
  assign div_busy = (div_st != IDLE);
  assign div_done = (div_st == DONE) && !mul_done;

`ifdef COMPLEX_DIV_EARLY_OUT_EN
  assign early = (in_src2 == '0) || (in_src1 < in_src2);
`else
  assign early = 1'b0;
`endif

  always_comb begin
    div_nxt = div_st;
    case (div_st)
      IDLE:    if (acc_div) div_nxt = early ? DONE : BUSY;
      BUSY:    if (d_cnt == CW'(1)) div_nxt = DONE;
      DONE:    if (!mul_done) div_nxt = IDLE;
      default: div_nxt = IDLE;
    endcase
    if (flush) div_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) div_st <= IDLE;
    else        div_st <= div_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_rem    <= '0;
      d_quo    <= '0;
      d_dvs    <= '0;
      d_cnt    <= '0;
      d_rem_op <= 1'b0;
      d_tag    <= '0;
    end else if (acc_div) begin
      d_quo    <= early ? ((in_src2 == '0) ? '1 : '0) : in_src1;
      d_rem    <= early ? in_src1 : '0;
      d_dvs    <= in_src2;
      d_cnt    <= CW'(W);
      d_rem_op <= in_op[0];
      d_tag    <= in_tag;
    end else if (div_st == BUSY) begin
      d_rem <= fits ? diff : trial[W-1:0];
      d_quo <= {d_quo[W-2:0], fits};
      d_cnt <= d_cnt - CW'(1);
    end
  end

  // Writeback: a completing multiply always wins; the divider waits in DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
    end else begin
      out_valid <= !flush && (mul_done || div_done);
      if (mul_done) begin
        out_data <= mul_data;
        out_tag  <= mul_tag;
      end else if (div_done) begin
        out_data <= d_rem_op ? d_rem : d_quo;
        out_tag  <= d_tag;
      end
    end
  end
endmodule

// File: tb/tb_complex_exec_pipe.sv
// Self-checking bench for complex_exec_pipe: directed scenarios plus a randomized run
// against a cycle-level reference model of results, latencies and divider occupancy.
module tb_complex_exec_pipe;
  localparam int W  = 32;
  localparam int TW = 7;
  localparam int ML = 3;

  logic          clk, reset, flush, in_valid;
  logic [1:0]    in_op;
  logic [W-1:0]  in_src1, in_src2;
  logic [TW-1:0] in_tag;
  logic          div_busy, out_valid;
  logic [W-1:0]  out_data;
  logic [TW-1:0] out_tag;

  int tests_run = 0;
  int fails     = 0;

  complex_exec_pipe #(.DATA_WIDTH(W), .TAG_WIDTH(TW), .MUL_LAT(ML)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_op(in_op),
    .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag), .div_busy(div_busy),
    .out_valid(out_valid), .out_data(out_data), .out_tag(out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    case (op)
      2'd0:    return p[31:0];
      2'd1:    return p[63:32];
      2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int div_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef COMPLEX_DIV_EARLY_OUT_EN
    if (b == 0 || a < b) return 2;
`endif
    return W + 2;
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_in();
    in_valid = 1'b0; in_op = 2'd0; in_src1 = '0; in_src2 = '0; in_tag = '0; flush = 1'b0;
  endtask

  task automatic put(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [6:0] t);
    in_valid = 1'b1; in_op = op; in_src1 = a; in_src2 = b; in_tag = t;
  endtask

  // Waits for the next out_valid; lat is cycles since the op was presented, -1 on timeout.
  task automatic wait_out(input int max, output int lat);
    lat = -1;
    for (int i = 1; i <= max; i++) begin
      step();
      if (i == 1) in_valid = 1'b0;
      if (out_valid === 1'b1) begin
        lat = i;
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_in();
    step(); step();
    tests_run++;
    if ({out_valid, div_busy, out_data, out_tag} !== '0) begin
      fails++;
      $display("FAIL reset_state got v=%b busy=%b data=%h tag=%h, required all zero",
               out_valid, div_busy, out_data, out_tag);
    end
    reset = 1'b1;
    step(); step();
  endtask

  task automatic test_mul_basic();
    int lat;
    logic [31:0] a, b;
    for (int k = 0; k < 4; k++) begin
      a = (k < 2) ? 32'h0001_0000 : $urandom;
      b = (k < 2) ? 32'h0001_0000 : $urandom;
      put(2'(k % 2), a, b, 7'(5 + k));
      wait_out(10, lat);
      tests_run++;
      if (lat !== ML || out_data !== ref_res(2'(k % 2), a, b) || out_tag !== 7'(5 + k)) begin
        fails++;
        $display("FAIL mul_basic k=%0d got lat=%0d data=%h tag=%0d, required lat=%0d data=%h tag=%0d",
                 k, lat, out_data, out_tag, ML, ref_res(2'(k % 2), a, b), 5 + k);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c <= 11; c++) begin
      tests_run++;
      if (c >= 3 && c <= 10) begin
        if (out_valid !== 1'b1 || out_data !== 32'(3 * (c - 3)) || out_tag !== 7'(20 + c - 3)) begin
          fails++;
          $display("FAIL mul_stream c=%0d got v=%b data=%0d tag=%0d, required v=1 data=%0d tag=%0d",
                   c, out_valid, out_data, out_tag, 3 * (c - 3), 20 + c - 3);
        end
      end else if (out_valid !== 1'b0) begin
        fails++;
        $display("FAIL mul_stream c=%0d got v=%b, required v=0", c, out_valid);
      end
      if (c < 8) put(2'd0, 32'(c), 32'd3, 7'(20 + c));
      else       idle_in();
      step();
    end
  endtask

  task automatic test_div();
    int lat, extra;
    logic [31:0] d;
    logic [6:0] t;
    logic busy1, busy35;
    for (int k = 0; k < 2; k++) begin
      put(2'(2 + k), 32'd100, 32'd7, 7'd9);
      lat = -1; extra = 0; d = '0; t = '0; busy1 = 1'b0; busy35 = 1'b1;
      for (int c = 1; c <= 45; c++) begin
        step();
        if (c == 1) begin in_valid = 1'b0; busy1 = div_busy; end
        if (c == 5) put(2'd2, 32'd1, 32'd1, 7'd99);
        if (c == 6) in_valid = 1'b0;
        if (c == 35) busy35 = div_busy;
        if (out_valid === 1'b1) begin
          if (lat < 0) begin lat = c; d = out_data; t = out_tag; end
          else extra++;
        end
      end
      tests_run++;
      if (lat !== 34 || d !== ((k == 0) ? 32'd14 : 32'd2) || t !== 7'd9) begin
        fails++;
        $display("FAIL div_100_7 k=%0d got lat=%0d data=%0d tag=%0d, required lat=34 data=%0d tag=9",
                 k, lat, d, t, (k == 0) ? 14 : 2);
      end
      tests_run++;
      if (busy1 !== 1'b1 || busy35 !== 1'b0 || extra !== 0) begin
        fails++;
        $display("FAIL div_busy k=%0d got busy@1=%b busy@35=%b extra=%0d, required 1 0 0",
                 k, busy1, busy35, extra);
      end
    end
  endtask

  task automatic test_div_zero();
    int lat;
    logic [31:0] a;
    for (int k = 0; k < 2; k++) begin
      a = (k == 0) ? 32'hFFFF_FFFF : 32'd5;
      put(2'(2 + k), a, 32'd0, 7'(1 + k));
      wait_out(60, lat);
      tests_run++;
      if (lat !== div_lat(a, 0) || out_data !== ref_res(2'(2 + k), a, 0) || out_tag !== 7'(1 + k)) begin
        fails++;
        $display("FAIL div_zero k=%0d got lat=%0d data=%h tag=%0d, required lat=%0d data=%h tag=%0d",
                 k, lat, out_data, out_tag, div_lat(a, 0), ref_res(2'(2 + k), a, 0), 1 + k);
      end
      step();
    end
  endtask

  task automatic test_collision();
    logic [31:0] a, b;
    a = $urandom; b = $urandom;
    put(2'd2, 32'd50, 32'd5, 7'd3);
    for (int c = 1; c <= 38; c++) begin
      step();
      if (c == 1) in_valid = 1'b0;
      if (c == 31) put(2'd0, a, b, 7'd4);
      if (c == 32) in_valid = 1'b0;
      if (c == 34) begin
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== ref_res(2'd0, a, b) || out_tag !== 7'd4 || div_busy !== 1'b1) begin
          fails++;
          $display("FAIL collide_mul got v=%b data=%h tag=%0d busy=%b, required v=1 data=%h tag=4 busy=1",
                   out_valid, out_data, out_tag, div_busy, ref_res(2'd0, a, b));
        end
      end
      if (c == 35) begin
        tests_run++;
        if (out_valid !== 1'b1 || out_data !== 32'd10 || out_tag !== 7'd3 || div_busy !== 1'b0) begin
          fails++;
          $display("FAIL collide_div got v=%b data=%0d tag=%0d busy=%b, required v=1 data=10 tag=3 busy=0",
                   out_valid, out_data, out_tag, div_busy);
        end
      end
      if (c == 36) begin
        tests_run++;
        if (out_valid !== 1'b0) begin
          fails++;
          $display("FAIL collide_after got v=%b, required v=0", out_valid);
        end
      end
    end
  endtask

  task automatic test_flush();
    int cnt, first;
    logic [31:0] d;
    logic [6:0] t;
    logic busy5;
    cnt = 0; first = -1; d = '0; t = '0; busy5 = 1'b1;
    put(2'd2, 32'd1000, 32'd3, 7'd10);
    for (int c = 1; c <= 45; c++) begin
      step();
      if (c == 1 || c == 3 || c == 6) idle_in();
      if (c == 2) put(2'd0, 32'd7, 32'd9, 7'd11);
      if (c == 4) begin put(2'd0, 32'd5, 32'd5, 7'd12); flush = 1'b1; end
      if (c == 5) begin idle_in(); busy5 = div_busy; put(2'd2, 32'd77, 32'd5, 7'd13); end
      if (out_valid === 1'b1) begin
        cnt++;
        if (first < 0) begin first = c; d = out_data; t = out_tag; end
      end
    end
    tests_run++;
    if (busy5 !== 1'b0) begin
      fails++;
      $display("FAIL flush_busy got busy@5=%b, required 0", busy5);
    end
    tests_run++;
    if (cnt !== 1 || first !== 39 || d !== 32'd15 || t !== 7'd13) begin
      fails++;
      $display("FAIL flush_result got count=%0d first=%0d data=%0d tag=%0d, required 1 39 15 13",
               cnt, first, d, t);
    end
  endtask

  task automatic test_reset_mid();
    int cnt;
    cnt = 0;
    put(2'd2, 32'd100, 32'd7, 7'd20);
    for (int c = 1; c <= 60; c++) begin
      step();
      if (c == 1 || c == 11) in_valid = 1'b0;
      if (c == 10) put(2'd0, $urandom, $urandom, 7'd21);
      if (c == 12) begin
        reset = 1'b0;
        #1;
        tests_run++;
        if ({out_valid, div_busy, out_data, out_tag} !== '0) begin
          fails++;
          $display("FAIL reset_mid got v=%b busy=%b data=%h tag=%h, required all zero",
                   out_valid, div_busy, out_data, out_tag);
        end
      end
      if (c == 13) reset = 1'b1;
      if (c > 12 && (out_valid === 1'b1 || div_busy === 1'b1)) cnt++;
    end
    tests_run++;
    if (cnt !== 0) begin
      fails++;
      $display("FAIL reset_mid_stale got %0d active cycles, required 0", cnt);
    end
  endtask

  task automatic test_random();
    logic [31:0] mexp_data[int];
    logic [6:0]  mexp_tag[int];
    bit          dpend, ev, eb;
    int          dready, r;
    logic [31:0] dexp, ed, a, b;
    logic [6:0]  dtag, et, t;
    logic [1:0]  op;
    dpend = 0; dready = 0; dexp = '0; dtag = '0;
    for (int c = 0; c < 700; c++) begin
      ev = 0; ed = '0; et = '0;
      if (mexp_data.exists(c)) begin
        ev = 1; ed = mexp_data[c]; et = mexp_tag[c];
      end else if (dpend && c >= dready) begin
        ev = 1; ed = dexp; et = dtag; dpend = 0;
      end
      eb = dpend;
      tests_run++;
      if (out_valid !== ev || div_busy !== eb) begin
        fails++;
        $display("FAIL rand_ctrl c=%0d got v=%b busy=%b, required v=%b busy=%b",
                 c, out_valid, div_busy, ev, eb);
      end
      if (ev) begin
        tests_run++;
        if (out_data !== ed || out_tag !== et) begin
          fails++;
          $display("FAIL rand_data c=%0d got data=%h tag=%0d, required data=%h tag=%0d",
                   c, out_data, out_tag, ed, et);
        end
      end
      idle_in();
      if (c < 600 && $urandom_range(0, 3) != 0) begin
        r  = $urandom_range(0, 9);
        op = (r < 7) ? 2'(r % 2) : 2'(2 + r % 2);
        a  = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
        b  = ($urandom_range(0, 6) == 0) ? 32'd0 :
             (($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 1000)) : $urandom);
        t  = 7'($urandom);
        put(op, a, b, t);
        if (!op[1]) begin
          mexp_data[c + ML] = ref_res(op, a, b);
          mexp_tag[c + ML]  = t;
        end else if (!eb) begin
          dpend = 1; dready = c + div_lat(a, b); dexp = ref_res(op, a, b); dtag = t;
        end
      end
      step();
    end
    idle_in();
  endtask

  initial begin
    idle_in();
    test_reset();
    test_mul_basic();
    test_back_to_back();
    step(); step();
    test_div();
    test_div_zero();
    test_collision();
    step(); step();
    test_flush();
    step(); step();
    test_reset_mid();
    step(); step();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
